// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU execution unit: data width, iteration counter
// sizing, 6-bit ALU control opcodes, the control state enum and a helper that
// evaluates every single-cycle operation.
// MUL is deliberately absent from alu_eval so that the iterative build never
// infers a combinational multiplier; the top decides how MUL is executed.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_MUL = 6'b011000;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SLL = 6'b000000;
  localparam logic [5:0] OP_SRL = 6'b000010;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              illegal;
  } alu_res_t;

  // Single-cycle operations; any code not listed (MUL included) reports
  // illegal with a zero result, the caller intercepts MUL beforehand.
  function automatic alu_res_t alu_eval(input logic [5:0]        op,
                                        input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b,
                                        input logic [4:0]        shamt);
    alu_res_t r;
    r.result  = {DATA_W{1'b0}};
    r.illegal = 1'b0;
    case (op)
      OP_ADD:  r.result = a + b;
      OP_SUB:  r.result = a - b;
      OP_AND:  r.result = a & b;
      OP_OR:   r.result = a | b;
      OP_NOR:  r.result = ~(a | b);
      OP_XOR:  r.result = a ^ b;
      OP_SLL:  r.result = b << shamt;
      OP_SRL:  r.result = b >> shamt;
      default: begin
        r.result  = {DATA_W{1'b0}};
        r.illegal = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_shift_add_mul.sv
// -----------------------------------------------------------------------------
// alu_shift_add_mul
// Iterative shift-add multiplier datapath, one step per cycle, 32 steps.
// Produces the low DATA_W bits of a*b.
// Ports:
//   clk_i       clock
//   reset_i     synchronous active-high reset
//   start_i     load operands, clear accumulator and counter
//   run_i       perform one shift-add step this cycle
//   a_i, b_i    operands (only sampled on start_i)
//   done_o      this cycle performs the final step (counter = 31)
//   product_o   accumulator value after this cycle's step
// -----------------------------------------------------------------------------
module alu_shift_add_mul
  import alu_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              run_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state: load on start, otherwise one shift-add step while running.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = {DATA_W{1'b0}};
      cnt_d    = {CNT_W{1'b0}};
    end else if (run_i) begin
      // Bits shifted out of the multiplicand are beyond the kept product width.
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 5'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mcand_q  <= {DATA_W{1'b0}};
      mplier_q <= {DATA_W{1'b0}};
      acc_q    <= {DATA_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign done_o    = run_i && (cnt_q == CNT_LAST);
  assign product_o = acc_d;

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// ALU execution unit with registered outputs. All ops except MUL complete in
// one cycle; MUL uses the iterative shift-add multiplier (33-cycle latency)
// unless the macro ALU_FAST_MUL_EN is defined, in which case MUL is a
// single-cycle op and neither the MUL state nor the counter is built.
// Ports:
//   clk_i          clock
//   reset_i        synchronous active-high reset (priority over start_i)
//   start_i        request pulse, ignored while busy_o
//   alu_control_i  6-bit operation code
//   a_i, b_i       operands (rs, rt)
//   shamt_i        shift amount for SLL/SRL
//   busy_o         iterative MUL in flight
//   done_o         one-cycle pulse, result_o/zero_o/illegal_o valid
//   result_o       registered result, held until the next done_o
//   zero_o         registered (result_o == 0)
//   illegal_o      pulses with done_o for unsupported codes
// -----------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [5:0]        alu_control_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [4:0]        shamt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              illegal_o
);

  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              zero_q, zero_d;
  logic [DATA_W-1:0] result_q, result_d;
  alu_res_t          eval_s;

  assign eval_s = alu_eval(alu_control_i, a_i, b_i, shamt_i);

`ifdef ALU_FAST_MUL_EN

  // Output next-state: every accepted op, MUL included, completes next cycle.
  always_comb begin
    done_d    = 1'b0;
    illegal_d = 1'b0;
    result_d  = result_q;
    zero_d    = zero_q;
    if (start_i) begin
      done_d = 1'b1;
      if (alu_control_i == OP_MUL) begin
        result_d = a_i * b_i;
      end else begin
        result_d  = eval_s.result;
        illegal_d = eval_s.illegal;
      end
      zero_d = (result_d == {DATA_W{1'b0}});
    end else begin
      done_d = 1'b0;
    end
  end

  assign busy_o = 1'b0;

`else

  state_e            state_q, state_d;
  logic              mul_start_s;
  logic              mul_run_s;
  logic              mul_done_s;
  logic [DATA_W-1:0] mul_product_s;

  assign mul_run_s = (state_q == ST_MUL);

  alu_shift_add_mul u_mul (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (mul_start_s),
    .run_i     (mul_run_s),
    .a_i       (a_i),
    .b_i       (b_i),
    .done_o    (mul_done_s),
    .product_o (mul_product_s)
  );

  // Control FSM next-state and output next-state.
  always_comb begin
    state_d     = state_q;
    mul_start_s = 1'b0;
    done_d      = 1'b0;
    illegal_d   = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (alu_control_i == OP_MUL) begin
            state_d     = ST_MUL;
            mul_start_s = 1'b1;
          end else begin
            done_d    = 1'b1;
            result_d  = eval_s.result;
            illegal_d = eval_s.illegal;
            zero_d    = (eval_s.result == {DATA_W{1'b0}});
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        // start_i is ignored here; the operands were latched on entry.
        if (mul_done_s) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          result_d = mul_product_s;
          zero_d   = (mul_product_s == {DATA_W{1'b0}});
        end else begin
          state_d = ST_MUL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy_o = mul_run_s;

`endif

  // Registered result and status outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= {DATA_W{1'b0}};
      zero_q    <= 1'b1;
    end else begin
      done_q    <= done_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
    end
  end

  assign done_o    = done_q;
  assign illegal_o = illegal_q;
  assign result_o  = result_q;
  assign zero_o    = zero_q;

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 Start  input  1  request pulse; sampled only when Busy=0.
REQ-004 ALUControl  input  6  operation code from the ALU control decoder.
REQ-005 A  input  32  operand A (rs).
REQ-006 B  input  32  operand B (rt).
REQ-007 Shamt  input  5  shift amount for SLL/SRL.
REQ-008 Busy  output  1  high while a multi-cycle operation is in flight.
REQ-009 Done  output  1  one-cycle pulse; Result/Zero/Illegal are valid in this cycle.
REQ-010 Result  output  32  registered result; holds until the next Done.
REQ-011 Zero  output  1  registered; equals (Result == 0).
REQ-012 Illegal  output  1  pulses with Done when ALUControl is unsupported.

Function
REQ-013 Supported codes: 100000 ADD, 100010 SUB, 011000 MUL, 100100 AND, 100101 OR, 100111 NOR, 100110 XOR, 000000 SLL (B << Shamt), 000010 SRL (B >> Shamt, logical).
REQ-014 States: IDLE, MUL; reset state IDLE.
REQ-015 In IDLE with Start=1 and a non-MUL code, the block registers the result and asserts Done in the next cycle (latency 1); it stays in IDLE and Busy stays 0.
REQ-016 In IDLE with Start=1 and code MUL, the block latches A and B, clears the accumulator and iteration counter, and moves to MUL; Busy=1 from the next cycle.
REQ-017 The MUL state performs one shift-add step per cycle for exactly 32 cycles, using a 5-bit counter that runs 0..31.
REQ-018 After the step with counter=31, the block returns to IDLE, drives Done=1 and Busy=0 in the same cycle, and the Result is valid; Start-to-Done latency is 33 cycles.
REQ-019 MUL Result is the low 32 bits of A*B (wrap-around; signedness irrelevant); ADD/SUB wrap modulo 2^32 with no overflow flag.
REQ-020 Start while Busy=1 is ignored; no queuing.
REQ-021 Start in the same cycle as Done (back-to-back) is accepted.
REQ-022 Operand/ALUControl changes during MUL do not affect the result.
REQ-023 Unsupported code: Done after 1 cycle, Result=0, Zero=1, Illegal=1.
REQ-024 Done and Illegal are never asserted except as single-cycle pulses.

Reset
REQ-025 Reset: state=IDLE, Busy=0, Done=0, Illegal=0, Result=0, Zero=1, counter=0, accumulator=0.
REQ-026 Reset during MUL aborts the operation; no Done is produced for it.
REQ-027 Reset has priority over Start in the same cycle.

Configuration
REQ-028 Macro ALU_FAST_MUL_EN defined: MUL completes in a single cycle, like the other ops (latency 1, Busy never asserted); the MUL state and the counter are not built.
REQ-029 Macro ALU_FAST_MUL_EN undefined: the iterative 33-cycle MUL of REQ-016..018 is used.

Structure
REQ-030 Shared package alu_pkg holds the 6-bit opcode constants, the state enum (IDLE, MUL), and the data-width constant (32).
REQ-031 A single sub-module, alu_shift_add_mul, holds the iterative multiplier datapath (multiplicand, multiplier, accumulator, counter) with start and done ports.

Verification
REQ-032 ADD, A=5, B=7, Start -> next cycle Done=1, Result=12, Zero=0, Illegal=0.
REQ-033 SUB, A=3, B=3 -> Done after 1 cycle, Result=0, Zero=1; SRL, B=0x80000000, Shamt=31 -> Result=1.
REQ-034 MUL, A=0xFFFFFFFF, B=2 -> Busy high 32 cycles, Done exactly 33 cycles after Start, Result=0xFFFFFFFE; with ALU_FAST_MUL_EN, Done after 1 cycle.
REQ-035 MUL in flight, then Start with ADD at cycle 5 -> ignored; the only Done is the MUL Done, carrying the MUL result.
REQ-036 Reset asserted at cycle 10 of a MUL -> next cycle Busy=0, Result=0; no Done follows.
REQ-037 ALUControl=111111, Start -> Done and Illegal pulse together, Result=0, Zero=1.
